// File: rtl/design_select_sequencer.sv
// Routes pad io to one of NUM_DES design slots, switching safely: the selection is synchronised,
// io_out is blanked and the new design is held in reset for RST_CYCLES before it is connected.
module design_select_sequencer #(
    parameter int unsigned NUM_DES     = 64,
    parameter int unsigned IO_W        = 12,
    parameter int unsigned SEL_W       = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_CYCLES  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IO_W-1:0]         io_in,
    output logic [IO_W-1:0]         io_out,
    input  logic [SEL_W-1:0]        des_sel,
    input  logic                    hold_if_not_sel,
    input  logic                    sync_inputs,
    output logic [NUM_DES*IO_W-1:0] des_io_in,
    input  logic [NUM_DES*IO_W-1:0] des_io_out,
    output logic [NUM_DES-1:0]      des_reset,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    switching
);

    localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [0:0] {StRun, StSwRst} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_meta_q, sel_s_q, sel_cmp_q;
    logic [IO_W-1:0]  io_sync_q [SYNC_STAGES];
    logic [IO_W-1:0]  io_path;
    logic [IO_W-1:0]  sel_out;

    // sel_cmp_q is the compare stage, so the FSM never sees a stale mismatch after it updates
    // active_sel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_meta_q <= '0;
            sel_s_q    <= '0;
            sel_cmp_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) io_sync_q[i] <= '0;
        end else begin
            sel_meta_q   <= des_sel;
            sel_s_q      <= sel_meta_q;
            sel_cmp_q    <= sel_s_q;
            io_sync_q[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) io_sync_q[i] <= io_sync_q[i-1];
        end
    end

    assign io_path   = sync_inputs ? io_sync_q[SYNC_STAGES-1] : io_in;
    assign switching = (state_q != StRun);

    // Out-of-range selections match no slot, so they see no inputs, outputs or switch reset.
    always_comb begin
        sel_out   = '0;
        des_io_in = '0;
        des_reset = '0;
        for (int i = 0; i < NUM_DES; i++) begin
            if (SEL_W'(i) == active_sel) begin
                sel_out                   = des_io_out[i*IO_W +: IO_W];
                des_io_in[i*IO_W +: IO_W] = io_path;
                des_reset[i]              = ~reset | switching;
            end else begin
                des_reset[i] = ~reset | hold_if_not_sel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StSwRst;
            cnt_q      <= '0;
            active_sel <= '0;
            io_out     <= '0;
        end else begin
            io_out <= (state_q == StRun) ? sel_out : '0;
            if (sel_cmp_q != active_sel) begin
                active_sel <= sel_cmp_q;
                cnt_q      <= '0;
                state_q    <= StSwRst;
            end else if (state_q == StSwRst) begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_q   <= '0;
                    state_q <= StRun;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_design_select_sequencer.sv
// Randomised bench for design_select_sequencer against a countdown/delay-queue reference model.
module tb_design_select_sequencer;

    localparam int NUM_DES = 64;
    localparam int IO_W    = 12;
    localparam int SEL_W   = 6;
    localparam int SYNC    = 2;
    localparam int RSTC    = 4;
    localparam int W       = NUM_DES * IO_W;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [IO_W-1:0]         io_in = '0;
    logic [IO_W-1:0]         io_out;
    logic [SEL_W-1:0]        des_sel = '0;
    logic                    hold_if_not_sel = 1'b0;
    logic                    sync_inputs = 1'b0;
    logic [W-1:0]            des_io_in;
    logic [W-1:0]            des_io_out = '0;
    logic [NUM_DES-1:0]      des_reset;
    logic [SEL_W-1:0]        active_sel;
    logic                    switching;

    design_select_sequencer #(
        .NUM_DES(NUM_DES), .IO_W(IO_W), .SEL_W(SEL_W), .SYNC_STAGES(SYNC), .RST_CYCLES(RSTC)
    ) dut (
        .clock(clock), .reset(reset), .io_in(io_in), .io_out(io_out), .des_sel(des_sel),
        .hold_if_not_sel(hold_if_not_sel), .sync_inputs(sync_inputs), .des_io_in(des_io_in),
        .des_io_out(des_io_out), .des_reset(des_reset), .active_sel(active_sel),
        .switching(switching)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining = reset cycles left for the active slot (0 means connected).
    int              remaining;
    int              act;
    int              sel_pipe[$];
    logic [IO_W-1:0] io_pipe[$];
    logic [IO_W-1:0] exp_io_out;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        remaining  = RSTC;
        act        = 0;
        sel_pipe   = {0, 0, 0};
        io_pipe    = {12'h0, 12'h0};
        exp_io_out = '0;
    endtask

    // Called at each active edge with reset high, using the inputs seen at that edge.
    task automatic model_step();
        int seen;
        seen = sel_pipe[$];
        exp_io_out = (remaining == 0 && act < NUM_DES) ? des_io_out[act*IO_W +: IO_W] : '0;
        if (seen != act) begin
            act       = seen;
            remaining = RSTC;
        end else if (remaining > 0) begin
            remaining--;
        end
        sel_pipe.push_front(int'(des_sel));
        void'(sel_pipe.pop_back());
        io_pipe.push_front(io_in);
        void'(io_pipe.pop_back());
    endtask

    task automatic check_all();
        logic [NUM_DES-1:0] exp_rst;
        logic [W-1:0]       exp_din;
        logic [IO_W-1:0]    path;
        path    = sync_inputs ? io_pipe[$] : io_in;
        exp_din = '0;
        for (int i = 0; i < NUM_DES; i++) begin
            if (i == act) begin
                exp_rst[i] = !reset || remaining != 0;
                exp_din[i*IO_W +: IO_W] = path;
            end else begin
                exp_rst[i] = !reset || hold_if_not_sel;
            end
        end
        check("switching", W'(switching), W'(remaining != 0));
        check("active_sel", W'(active_sel), W'(act));
        check("io_out", W'(io_out), W'(exp_io_out));
        check("des_reset", W'(des_reset), W'(exp_rst));
        check("des_io_in", des_io_in, exp_din);
    endtask

    task automatic drive_data();
        for (int i = 0; i < W / 32; i++) des_io_out[i*32 +: 32] = $urandom;
        io_in = IO_W'($urandom);
    endtask

    // Entered and left at a negedge.
    task automatic run_cycle();
        @(posedge clock);
        model_step();
        #1 check_all();
        @(negedge clock);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_data();
            run_cycle();
        end
    endtask

    // Asynchronous reset pulse away from any clock edge; entered and left at a negedge.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clock);
        #1 check_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        check_all();
        @(negedge clock);
        check_all();

        // Release with slot 1 requested, then 1->2, then 2->5->7 with 7 arriving mid-switch.
        des_sel = 1;
        reset   = 1'b1;
        run_cycles(14);
        des_sel = 2;
        run_cycles(12);
        des_sel = 5;
        run_cycles(5);
        des_sel = 7;
        run_cycles(12);
        hold_if_not_sel = 1'b1;
        run_cycles(3);
        hold_if_not_sel = 1'b0;
        sync_inputs     = 1'b1;
        run_cycles(3);
        io_in = 12'hA5C;
        run_cycle();
        run_cycle();
        run_cycle();
        sync_inputs = 1'b0;
        io_in = 12'h3C1;
        run_cycle();
        // Reset in the middle of a switch.
        des_sel = 9;
        run_cycles(4);
        pulse_reset();
        run_cycles(12);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_data();
            if ($urandom_range(0, 9) == 0)   des_sel = SEL_W'($urandom_range(0, NUM_DES - 1));
            if ($urandom_range(0, 39) == 0)  hold_if_not_sel = ~hold_if_not_sel;
            if ($urandom_range(0, 199) == 0) sync_inputs = ~sync_inputs;
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
